// File: rtl/fpu_pkg.sv
// Shared opcode, flag-index and result-payload definitions for the FPU result stage.
package fpu_pkg;

  localparam int unsigned RES_DATA_W = 64;
  localparam int unsigned RES_OP_W   = 4;
  localparam int unsigned FLAG_W     = 4;

  localparam logic [RES_OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [RES_OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [RES_OP_W-1:0] OP_MUL = 4'd3;
  localparam logic [RES_OP_W-1:0] OP_DIV = 4'd4;
  localparam logic [RES_OP_W-1:0] OP_AND = 4'd5;
  localparam logic [RES_OP_W-1:0] OP_OR  = 4'd6;
  localparam logic [RES_OP_W-1:0] OP_XOR = 4'd7;
  localparam logic [RES_OP_W-1:0] OP_SLL = 4'd8;
  localparam logic [RES_OP_W-1:0] OP_SRL = 4'd9;
  localparam logic [RES_OP_W-1:0] OP_ITF = 4'd10;
  localparam logic [RES_OP_W-1:0] OP_FPI = 4'd11;

  localparam int unsigned FLG_EXC = 0;
  localparam int unsigned FLG_OVF = 1;
  localparam int unsigned FLG_UNF = 2;
  localparam int unsigned FLG_ILL = 3;

  typedef struct packed {
    logic [RES_DATA_W-1:0] data;
    logic [RES_OP_W-1:0]   op;
    logic [FLAG_W-1:0]     flags;
  } fpu_res_t;

endpackage

// File: rtl/fpu_skid_fifo.sv
// Two-entry valid/ready buffer; the head lives in its own register so that
// out_res keeps the last popped value while the buffer is empty.
module fpu_skid_fifo
  import fpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  fpu_res_t in_res,
  output logic     out_valid,
  input  logic     out_ready,
  output fpu_res_t out_res
);

  logic [1:0] count_q;
  logic [1:0] count_d;
  fpu_res_t   skid_q;
  logic       push;
  logic       pop;

  always_comb begin
    push    = in_valid & in_ready;
    pop     = out_valid & out_ready;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Head/skid move: a push lands in the head when it is (or becomes) free.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_res   <= '0;
      skid_q    <= '0;
    end else begin
      count_q   <= count_d;
      in_ready  <= (count_d != 2'd2);
      out_valid <= (count_d != 2'd0);
      if (push && (count_q == 2'd0 || pop)) begin
        out_res <= in_res;
      end else if (push) begin
        skid_q <= in_res;
      end else if (pop && count_q == 2'd2) begin
        out_res <= skid_q;
      end
    end
  end

endmodule

// File: rtl/fpu_result_stage.sv
// FPU result stage: sanitises ALU flags, buffers results for writeback and
// keeps sticky status bits plus saturating result/exception counters.
module fpu_result_stage
  import fpu_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_exc,
  input  logic              in_ovf,
  input  logic              in_unf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OP_W-1:0]   out_op,
  output logic [3:0]        out_flags,
  output logic [3:0]        sticky,
  input  logic              sticky_clr,
  output logic [CNT_W-1:0]  res_cnt,
  output logic [CNT_W-1:0]  exc_cnt,
  input  logic              cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [RES_OP_W-1:0] op_tag;
  logic                legal_op;
  logic                arith_op;
  logic                exc_op;
  logic                accept;
  fpu_res_t            res_c;
  fpu_res_t            head;
  logic [CNT_W-1:0]    res_base;
  logic [CNT_W-1:0]    exc_base;
  logic [CNT_W-1:0]    res_cnt_d;
  logic [CNT_W-1:0]    exc_cnt_d;

  // Ovf/unf only mean something for ADD/SUB/MUL, exc additionally for DIV.
  always_comb begin
    op_tag   = RES_OP_W'(in_op);
    legal_op = (op_tag >= OP_ADD) && (op_tag <= OP_FPI);
    arith_op = (op_tag >= OP_ADD) && (op_tag <= OP_MUL);
    exc_op   = (op_tag >= OP_ADD) && (op_tag <= OP_DIV);
    res_c    = '0;
    res_c.op = op_tag;
    if (legal_op) begin
      res_c.data           = RES_DATA_W'(in_data);
      res_c.flags[FLG_EXC] = in_exc & exc_op;
      res_c.flags[FLG_OVF] = in_ovf & arith_op;
      res_c.flags[FLG_UNF] = in_unf & arith_op;
    end else begin
      res_c.flags[FLG_ILL] = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

  fpu_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (res_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (head)
  );

  assign out_data  = DATA_W'(head.data);
  assign out_op    = OP_W'(head.op);
  assign out_flags = head.flags;

  // A clear coinciding with an accept still counts that accept.
  always_comb begin
    res_base  = cnt_clr ? '0 : res_cnt;
    exc_base  = cnt_clr ? '0 : exc_cnt;
    res_cnt_d = res_base;
    exc_cnt_d = exc_base;
    if (accept && res_base != CNT_MAX) begin
      res_cnt_d = res_base + CNT_W'(1);
    end
    if (accept && res_c.flags[FLG_EXC] && exc_base != CNT_MAX) begin
      exc_cnt_d = exc_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky  <= 4'b0000;
      res_cnt <= '0;
      exc_cnt <= '0;
    end else begin
      if (accept) begin
        sticky <= (sticky_clr ? 4'b0000 : sticky) | res_c.flags;
      end else if (sticky_clr) begin
        sticky <= 4'b0000;
      end
      res_cnt <= res_cnt_d;
      exc_cnt <= exc_cnt_d;
    end
  end

endmodule

// File: doc/fpu_result_stage.md
Name: fpu_result_stage

Overview:
Registered downstream stage that captures the combinational FPU ALU result, flags and opcode tag, and presents them over a valid/ready handshake to writeback.
- Sanitises the flags: Overflow/Underflow are meaningful only for ADD/SUB/MUL, and the ALU holds stale values for other ops.
- Keeps sticky IEEE-style status bits and event counters readable by software.
- Provides 2-entry buffering so a stalled consumer never drops an ALU result.

Parameters:
DATA_W, 64, result width (IEEE-754 double / integer result)
OP_W, 4, opcode tag width (matches ALU Operation)
CNT_W, 16, width of saturating event counters

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  issuer asserts when ALU inputs are stable and enabled this cycle
in_ready  output  1  stage can accept; equals (occupancy != 2), from registered state only
in_op  input  OP_W  Operation code driven to the ALU this cycle
in_data  input  DATA_W  ALU_Output
in_exc  input  1  ALU Exception
in_ovf  input  1  ALU Overflow
in_unf  input  1  ALU Underflow
out_valid  output  1  head entry holds a result
out_ready  input  1  consumer accepts head
out_data  output  DATA_W  head result
out_op  output  OP_W  head opcode tag
out_flags  output  4  head flags {illegal, unf, ovf, exc}
sticky  output  4  accumulated {illegal, unf, ovf, exc}
sticky_clr  input  1  clear sticky bits
res_cnt  output  CNT_W  results accepted, saturating
exc_cnt  output  CNT_W  results with exc=1, saturating
cnt_clr  input  1  clear both counters

Behaviour:
- Reset (synchronous, rst=1 at rising edge): occupancy 0, out_valid 0, out_data/out_op/out_flags 0, sticky 0, counters 0, in_ready 1 from the next cycle. Reset mid-operation discards both buffered entries without handshake.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Flag sanitising on accept:
  - legal op = 1..11.
  - ovf_m = in_ovf & op∈{1,2,3}; unf_m = in_unf & op∈{1,2,3}.
  - exc_m = in_exc & op∈{1,2,3,4}.
  - illegal = ~legal.
  - Illegal op stores data 0 and all other flags 0.
- Buffer: 2-entry FIFO, head/tail pointers wrap at 2.
  - Latency: accepted at edge N → out_valid=1 after edge N when empty (1 cycle).
  - Empty: out_valid=0; out_data holds the last popped value.
  - Full: in_ready=0; the issuer must hold its inputs.
  - Simultaneous accept and pop at occupancy 1: occupancy stays 1; head advances to the new entry.
  - Simultaneous accept and pop at occupancy 0: cannot occur.
  - Occupancy 2: only pop is possible.
- Ordering strictly FIFO; no entry is dropped or duplicated.
- Sticky: on accept, sticky |= sanitised flags. If sticky_clr is asserted in the same cycle as an accept, sticky = that accept's flags (set wins over clear). Otherwise sticky_clr → 0.
- Counters:
  - res_cnt +1 per accept; exc_cnt +1 per accept with exc_m.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr with a simultaneous accept gives 0 + increment (1 or 0).

Decomposition:
- Package fpu_pkg:
  - opcode localparams OP_ADD..OP_FPI (1..11);
  - flag bit indices FLG_EXC=0, FLG_OVF=1, FLG_UNF=2, FLG_ILL=3;
  - packed struct fpu_res_t {data, op, flags}.
- Sub-module fpu_skid_fifo: 2-entry valid/ready FIFO of fpu_res_t.
- Top: sanitising logic, sticky bits, counters.

Test Plan:
- After reset, in_valid=1, op=1, data=64'h4008000000000000, out_ready=1 → next cycle out_valid=1, out_data=64'h4008000000000000, out_flags=0, res_cnt=1.
- op=5 (AND) with in_ovf=1, in_unf=1, in_exc=1 → out_flags=4'b0000, sticky unchanged, exc_cnt unchanged.
- op=3 with in_ovf=1, in_exc=1 → out_flags=4'b0011, sticky=4'b0011, exc_cnt=1. Then sticky_clr alone → sticky=0.
- out_ready=0, push A,B,C back-to-back → in_ready=0 after B, C is held. Release out_ready → pops A, B, C in order with no loss.
- op=0 and op=14 → data 0, out_flags=4'b1000, sticky[3]=1. sticky_clr together with an op=2 accept carrying ovf → sticky=4'b0010.
- Preload res_cnt to max via 2^CNT_W−1 accepts (CNT_W=4 build) → stays 15. Assert rst while occupancy=2 → out_valid=0 and counters 0 next cycle.
